// File: rtl/icache_pkg.sv
// Shared encodings for the set-associative I-cache: FSM states and AXI response/burst codes.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_AR   = 2'd2,
        S_R    = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/icache_set_assoc_if.sv
// IFU-side AXI-Lite read channel and memory-side AXI burst read channel of the I-cache.
// The cache uses the slave modport; the IFU/memory environment uses master.
interface icache_set_assoc_if;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] out_araddr;
    logic        out_arvalid;
    logic        out_arready;
    logic [7:0]  out_arlen;
    logic [1:0]  out_arburst;
    logic [31:0] out_rdata;
    logic [1:0]  out_rresp;
    logic        out_rvalid;
    logic        out_rready;
    logic        out_rlast;

    modport slave (
        input  ifu_araddr, ifu_arvalid, ifu_rready,
               out_arready, out_rdata, out_rresp, out_rvalid, out_rlast,
        output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
               out_araddr, out_arvalid, out_arlen, out_arburst, out_rready
    );

    modport master (
        output ifu_araddr, ifu_arvalid, ifu_rready,
               out_arready, out_rdata, out_rresp, out_rvalid, out_rlast,
        input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
               out_araddr, out_arvalid, out_arlen, out_arburst, out_rready
    );
endinterface

// File: rtl/icache_set_assoc_tag_array.sv
// Tag/valid/round-robin state for all sets: combinational lookup plus fill and flush-all updates.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int SETS_DIG = 2,
    parameter int WAYS_DIG = 1,
    parameter int TAG_W    = 26
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [SETS_DIG-1:0]                     lk_set,
    input  logic [TAG_W-1:0]                        lk_tag,
    input  logic                                    fill_en,
    input  logic [SETS_DIG-1:0]                     fill_set,
    input  logic [((WAYS_DIG > 0) ? WAYS_DIG : 1)-1:0] fill_way,
    input  logic [TAG_W-1:0]                        fill_tag,
    input  logic                                    flush_all,
    output logic                                    hit,
    output logic [((WAYS_DIG > 0) ? WAYS_DIG : 1)-1:0] hit_way,
    output logic [((WAYS_DIG > 0) ? WAYS_DIG : 1)-1:0] victim_way
);
    localparam int SETS  = 1 << SETS_DIG;
    localparam int WAYS  = 1 << WAYS_DIG;
    localparam int WAY_W = (WAYS_DIG > 0) ? WAYS_DIG : 1;

    logic [TAG_W-1:0]             tag_q [SETS][WAYS];
    logic [TAG_W-1:0]             tag_d [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
    logic [WAY_W-1:0]             rr_q [SETS];
    logic [WAY_W-1:0]             rr_d [SETS];

    // Lowest-numbered invalid way wins; round-robin only once the set is full.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = rr_q[lk_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lk_set][w]) victim_way = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (fill_en) begin
            tag_d[fill_set][fill_way]   = fill_tag;
            valid_d[fill_set][fill_way] = 1'b1;
            rr_d[fill_set]              = (WAYS == 1) ? '0 : rr_q[fill_set] + 1'b1;
        end
        if (flush_all) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
        tag_q <= tag_d;
    end

endmodule

// File: rtl/icache_set_assoc.sv
// N-way set-associative I-cache: same-cycle hits, whole-line INCR refill on miss, fence_i flush.
// Optional ICACHE_PERF_EN adds 32-bit hit/miss counters (tied to 0 when undefined).
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int WORDS_DIG = 2,
    parameter int SETS_DIG  = 2,
    parameter int WAYS_DIG  = 1
) (
    input  logic              clk,
    input  logic              rst,
    icache_set_assoc_if.slave bus,
    input  logic              fence_i,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
);
    localparam int WORDS    = 1 << WORDS_DIG;
    localparam int SETS     = 1 << SETS_DIG;
    localparam int WAYS     = 1 << WAYS_DIG;
    localparam int LINE_LSB = 2 + WORDS_DIG;
    localparam int LINE_W   = 32 - LINE_LSB;
    localparam int TAG_W    = LINE_W - SETS_DIG;
    localparam int WORD_W   = (WORDS_DIG > 0) ? WORDS_DIG : 1;
    localparam int WAY_W    = (WAYS_DIG > 0) ? WAYS_DIG : 1;
    localparam int CNT_W    = WORD_W + 1;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              fence_pend_q, fence_pend_d;
    logic [31:0]       buf_q, buf_d;
    logic [1:0]        resp_q, resp_d;

    logic [31:0]       data_mem [SETS][WAYS][WORDS];

    logic [LINE_W-1:0] lk_line;
    logic [WORD_W-1:0] lk_word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way, victim_way;
    logic              fill_en, flush_all, mem_we;
    logic              hit_acc, miss_acc, short_burst, beat_bad;
    logic [31:0]       hit_word;

    assign lk_line = bus.ifu_araddr[31:LINE_LSB];

    if (WORDS_DIG > 0) begin : g_word
        assign lk_word = bus.ifu_araddr[LINE_LSB-1:2];
    end else begin : g_noword
        assign lk_word = 1'b0;
    end

    icache_tag_array #(
        .SETS_DIG (SETS_DIG),
        .WAYS_DIG (WAYS_DIG),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .lk_set     (lk_line[SETS_DIG-1:0]),
        .lk_tag     (lk_line[LINE_W-1:SETS_DIG]),
        .fill_en    (fill_en),
        .fill_set   (line_q[SETS_DIG-1:0]),
        .fill_way   (victim_q),
        .fill_tag   (line_q[LINE_W-1:SETS_DIG]),
        .flush_all  (flush_all),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    assign bus.ifu_arready = (state_q == S_IDLE) && !fence_i && !fence_pend_q;
    assign hit_acc         = bus.ifu_arready && bus.ifu_arvalid && hit;
    assign miss_acc        = bus.ifu_arready && bus.ifu_arvalid && !hit;
    assign hit_word        = data_mem[lk_line[SETS_DIG-1:0]][hit_way][lk_word];

    assign bus.ifu_rvalid  = hit_acc || (state_q == S_RESP);
    assign bus.ifu_rdata   = hit_acc ? hit_word : buf_q;
    assign bus.ifu_rresp   = hit_acc ? RESP_OKAY : resp_q;

    assign bus.out_araddr  = {line_q, {LINE_LSB{1'b0}}};
    assign bus.out_arvalid = (state_q == S_AR);
    assign bus.out_arlen   = 8'(WORDS - 1);
    assign bus.out_arburst = BURST_INCR;
    assign bus.out_rready  = (state_q == S_R);

    // rlast on any beat other than the last expected one means a truncated line.
    assign short_burst = (cnt_q != CNT_W'(WORDS - 1));
    assign beat_bad    = (bus.out_rresp != RESP_OKAY);

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        word_d       = word_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        buf_d        = buf_q;
        resp_d       = resp_q;
        fence_pend_d = fence_pend_q;
        fill_en      = 1'b0;
        flush_all    = 1'b0;
        mem_we       = 1'b0;

        if (state_q != S_IDLE && fence_i) fence_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (fence_i || fence_pend_q) begin
                    flush_all    = 1'b1;
                    fence_pend_d = 1'b0;
                end else if (hit_acc && !bus.ifu_rready) begin
                    buf_d   = hit_word;
                    resp_d  = RESP_OKAY;
                    state_d = S_RESP;
                end else if (miss_acc) begin
                    line_d   = lk_line;
                    word_d   = lk_word;
                    victim_d = victim_way;
                    err_d    = 1'b0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (bus.out_arready) begin
                    cnt_d   = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (bus.out_rvalid) begin
                    mem_we = (cnt_q < CNT_W'(WORDS));
                    if (cnt_q == CNT_W'(word_q)) buf_d = bus.out_rdata;
                    if (beat_bad) err_d = 1'b1;
                    if (cnt_q != CNT_W'(WORDS)) cnt_d = cnt_q + 1'b1;
                    if (bus.out_rlast) begin
                        fill_en = !(err_q || beat_bad || short_burst);
                        resp_d  = (err_q || beat_bad || short_burst) ? RESP_SLVERR : RESP_OKAY;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.ifu_rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            word_q       <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            buf_q        <= '0;
            resp_q       <= RESP_OKAY;
            fence_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            word_q       <= word_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            buf_q        <= buf_d;
            resp_q       <= resp_d;
            fence_pend_q <= fence_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) data_mem[line_q[SETS_DIG-1:0]][victim_q][cnt_q[WORD_W-1:0]] <= bus.out_rdata;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;

    always_comb begin
        perf_hit_d  = perf_hit_q + {31'd0, hit_acc};
        perf_miss_d = perf_miss_q + {31'd0, miss_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`else
    assign perf_hit  = '0;
    assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc (4 words/line, 4 sets, 2 ways); memory word = {addr[15:0], 16'hC0DE}.
module tb_icache_set_assoc;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fence_i;
    logic [31:0] perf_hit, perf_miss;
    int          checks = 0;
    int          errors = 0;

    icache_set_assoc_if bus ();

    icache_set_assoc #(
        .WORDS_DIG (2),
        .SETS_DIG  (2),
        .WAYS_DIG  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fence_i   (fence_i),
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    // One IFU fetch; on a miss the bench plays memory for the whole burst.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int err_beat,
                         input int nbeats, input bit fence_pulse, input string tag);
        logic [31:0] base;
        logic [1:0]  exp_resp;
        int          n;
        base     = a & 32'hFFFF_FFF0;
        exp_resp = (err_beat >= 0 || nbeats != 4) ? RESP_SLVERR : RESP_OKAY;
        @(negedge clk);
        bus.ifu_araddr  = a;
        bus.ifu_arvalid = 1'b1;
        bus.ifu_rready  = 1'b1;
        #1;
        chk({tag, ".arready"}, 32'(bus.ifu_arready), 32'd1);
        chk({tag, ".hit"}, 32'(bus.ifu_rvalid), 32'(exp_hit));
        if (exp_hit) begin
            chk({tag, ".hit_data"}, bus.ifu_rdata, mw(a));
            chk({tag, ".hit_resp"}, 32'(bus.ifu_rresp), 32'(RESP_OKAY));
            @(posedge clk); #1;
            bus.ifu_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.ifu_arvalid = 1'b0;
        n = 0;
        while (!bus.out_arvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".arvalid"}, 32'(bus.out_arvalid), 32'd1);
        chk({tag, ".araddr"}, bus.out_araddr, base);
        chk({tag, ".arlen"}, 32'(bus.out_arlen), 32'd3);
        bus.out_arready = 1'b1;
        @(posedge clk); #1;
        bus.out_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.out_rvalid = 1'b1;
            bus.out_rdata  = mw(base + 32'(4 * b));
            bus.out_rresp  = (b == err_beat) ? RESP_SLVERR : RESP_OKAY;
            bus.out_rlast  = (b == nbeats - 1);
            fence_i        = fence_pulse && (b == 0);
            if (b == 0) chk({tag, ".rready"}, 32'(bus.out_rready), 32'd1);
            @(posedge clk); #1;
        end
        fence_i        = 1'b0;
        bus.out_rvalid = 1'b0;
        bus.out_rlast  = 1'b0;
        bus.out_rresp  = RESP_OKAY;
        chk({tag, ".resp_valid"}, 32'(bus.ifu_rvalid), 32'd1);
        chk({tag, ".resp"}, 32'(bus.ifu_rresp), 32'(exp_resp));
        if (exp_resp == RESP_OKAY) chk({tag, ".resp_data"}, bus.ifu_rdata, mw(a));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        fence_i         = 1'b0;
        bus.ifu_araddr  = '0;
        bus.ifu_arvalid = 1'b0;
        bus.ifu_rready  = 1'b1;
        bus.out_arready = 1'b0;
        bus.out_rdata   = '0;
        bus.out_rresp   = RESP_OKAY;
        bus.out_rvalid  = 1'b0;
        bus.out_rlast   = 1'b0;
        do_reset();

        chk("rst.arready", 32'(bus.ifu_arready), 32'd1);
        chk("rst.rvalid", 32'(bus.ifu_rvalid), 32'd0);
        chk("rst.rresp", 32'(bus.ifu_rresp), 32'd0);
        chk("rst.rdata", bus.ifu_rdata, 32'd0);
        chk("rst.out_arvalid", 32'(bus.out_arvalid), 32'd0);
        chk("rst.out_rready", 32'(bus.out_rready), 32'd0);
        chk("rst.arburst", 32'(bus.out_arburst), 32'(BURST_INCR));
        chk("rst.perf_hit", perf_hit, 32'd0);
        chk("rst.perf_miss", perf_miss, 32'd0);

        // cold miss then same-line hit
        fetch(32'h8000_0004, 1'b0, -1, 4, 1'b0, "t1.cold");
        fetch(32'h8000_0004, 1'b1, -1, 4, 1'b0, "t1.rehit");

        // set 0 with two ways: third line evicts the oldest fill
        fetch(32'h8000_0000, 1'b1, -1, 4, 1'b0, "t2.a");
        fetch(32'h8000_0040, 1'b0, -1, 4, 1'b0, "t2.b");
        fetch(32'h8000_0080, 1'b0, -1, 4, 1'b0, "t2.c");
        fetch(32'h8000_0040, 1'b1, -1, 4, 1'b0, "t2.b_hit");
        fetch(32'h8000_0000, 1'b0, -1, 4, 1'b0, "t2.a_evicted");

        // hit held under rready=0
        @(negedge clk);
        bus.ifu_araddr  = 32'h8000_0088;
        bus.ifu_arvalid = 1'b1;
        bus.ifu_rready  = 1'b0;
        #1;
        chk("t3.hit", 32'(bus.ifu_rvalid), 32'd1);
        chk("t3.data0", bus.ifu_rdata, 32'h0088_C0DE);
        @(posedge clk); #1;
        bus.ifu_arvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3.held_valid", 32'(bus.ifu_rvalid), 32'd1);
            chk("t3.held_data", bus.ifu_rdata, 32'h0088_C0DE);
            chk("t3.arready_low", 32'(bus.ifu_arready), 32'd0);
        end
        bus.ifu_rready = 1'b1;
        @(posedge clk); #1;
        chk("t3.released", 32'(bus.ifu_arready), 32'd1);

        // error beat and truncated burst both leave the line invalid
        fetch(32'h8000_0110, 1'b0, 2, 4, 1'b0, "t4.err");
        fetch(32'h8000_0110, 1'b0, -1, 4, 1'b0, "t4.retry");
        fetch(32'h8000_0110, 1'b1, -1, 4, 1'b0, "t4.hit");
        fetch(32'h8000_0120, 1'b0, -1, 2, 1'b0, "t4.short");
        fetch(32'h8000_0120, 1'b0, -1, 4, 1'b0, "t4.short_retry");

        // fence during refill: refill responds, then first IDLE cycle flushes
        fetch(32'h8000_0024, 1'b0, -1, 4, 1'b1, "t5.fenced");
        #1;
        chk("t5.flush_cycle_arready", 32'(bus.ifu_arready), 32'd0);
        @(posedge clk); #1;
        chk("t5.after_flush_arready", 32'(bus.ifu_arready), 32'd1);
        fetch(32'h8000_0024, 1'b0, -1, 4, 1'b0, "t5.refetch");
        fetch(32'h8000_0110, 1'b0, -1, 4, 1'b0, "t5.other_flushed");

        // counters: 3 misses + 5 hits from a clean reset
        do_reset();
        fetch(32'h8000_0000, 1'b0, -1, 4, 1'b0, "t6.m1");
        fetch(32'h8000_0040, 1'b0, -1, 4, 1'b0, "t6.m2");
        fetch(32'h8000_0310, 1'b0, -1, 4, 1'b0, "t6.m3");
        fetch(32'h8000_0000, 1'b1, -1, 4, 1'b0, "t6.h1");
        fetch(32'h8000_0004, 1'b1, -1, 4, 1'b0, "t6.h2");
        fetch(32'h8000_0048, 1'b1, -1, 4, 1'b0, "t6.h3");
        fetch(32'h8000_031C, 1'b1, -1, 4, 1'b0, "t6.h4");
        fetch(32'h8000_0008, 1'b1, -1, 4, 1'b0, "t6.h5");
`ifdef ICACHE_PERF_EN
        chk("t6.perf_miss", perf_miss, 32'd3);
        chk("t6.perf_hit", perf_hit, 32'd5);
`else
        chk("t6.perf_miss_off", perf_miss, 32'd0);
        chk("t6.perf_hit_off", perf_hit, 32'd0);
`endif

        // reset in the middle of a refill
        @(negedge clk);
        bus.ifu_araddr  = 32'h8000_0200;
        bus.ifu_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.ifu_arvalid = 1'b0;
        bus.out_arready = 1'b1;
        @(posedge clk); #1;
        bus.out_arready = 1'b0;
        chk("t6.in_r", 32'(bus.out_rready), 32'd1);
        bus.out_rvalid  = 1'b1;
        bus.out_rdata   = 32'h0200_C0DE;
        rst             = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6.rst_arready", 32'(bus.ifu_arready), 32'd1);
        chk("t6.rst_rvalid", 32'(bus.ifu_rvalid), 32'd0);
        chk("t6.rst_late_beat_ignored", 32'(bus.out_rready), 32'd0);
        chk("t6.rst_arvalid", 32'(bus.out_arvalid), 32'd0);
        chk("t6.rst_perf_hit", perf_hit, 32'd0);
        chk("t6.rst_perf_miss", perf_miss, 32'd0);
        bus.out_rvalid = 1'b0;
        fetch(32'h8000_0000, 1'b0, -1, 4, 1'b0, "t6.post_rst_miss");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
